// File: rtl/mul_div_wb_queue.sv
// Writeback queue behind the multiplier and divider: an in-order FIFO of (rd, result)
// pairs drained one per cycle into the register-file write port.
module mul_div_wb_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       mul_valid_i,
    input  logic [DATA_W-1:0]          mul_data_i,
    input  logic [TAG_W-1:0]           mul_rd_i,
    output logic                       mul_ready_o,
    input  logic                       div_valid_i,
    input  logic [DATA_W-1:0]          div_data_i,
    input  logic [TAG_W-1:0]           div_rd_i,
    output logic                       div_ready_o,
    output logic                       wb_valid_o,
    output logic [TAG_W-1:0]           wb_rd_o,
    output logic [DATA_W-1:0]          wb_data_o,
    input  logic                       wb_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] Full     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] OneFree  = CNT_W'(DEPTH - 1);

    logic [TAG_W-1:0]  rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, div_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mul_enq, div_enq, pop;

    // Readies come only from the registered count; mul wins the last free slot.
    assign mul_ready_o = (count_q < Full);
    assign div_ready_o = (count_q < OneFree) || ((count_q < Full) && !mul_valid_i);

    // rd=0 results are handshaken but never stored.
    assign mul_enq = mul_valid_i && mul_ready_o && (mul_rd_i != '0) && !flush_i;
    assign div_enq = div_valid_i && div_ready_o && (div_rd_i != '0) && !flush_i;
    assign div_idx = wptr_q + PTR_W'(mul_enq);

    assign wb_valid_o = (count_q != '0);
    assign pop        = wb_valid_o && wb_ready_i;
    assign wb_rd_o    = wb_valid_o ? rd_mem[rptr_q]   : '0;
    assign wb_data_o  = wb_valid_o ? data_mem[rptr_q] : '0;
    assign count_o    = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + PTR_W'(mul_enq) + PTR_W'(div_enq);
            rptr_d  = rptr_q + PTR_W'(pop);
            count_d = count_q + CNT_W'(mul_enq) + CNT_W'(div_enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (mul_enq) begin
            rd_mem[wptr_q]   <= mul_rd_i;
            data_mem[wptr_q] <= mul_data_i;
        end
        if (div_enq) begin
            rd_mem[div_idx]   <= div_rd_i;
            data_mem[div_idx] <= div_data_i;
        end
    end

endmodule

// File: tb/tb_mul_div_wb_queue.sv
// Scoreboard bench for mul_div_wb_queue: a reference queue models occupancy, readies and
// output order; every negedge compares the DUT against it.
module tb_mul_div_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic        mul_valid_i = 1'b0;
    logic [31:0] mul_data_i = '0;
    logic [4:0]  mul_rd_i = '0;
    logic        mul_ready_o;
    logic        div_valid_i = 1'b0;
    logic [31:0] div_data_i = '0;
    logic [4:0]  div_rd_i = '0;
    logic        div_ready_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_ready_i = 1'b0;
    logic [2:0]  count_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t sb[$];

    mul_div_wb_queue #(.DEPTH(4), .DATA_W(32), .TAG_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush_i),
        .mul_valid_i (mul_valid_i),
        .mul_data_i  (mul_data_i),
        .mul_rd_i    (mul_rd_i),
        .mul_ready_o (mul_ready_o),
        .div_valid_i (div_valid_i),
        .div_data_i  (div_data_i),
        .div_rd_i    (div_rd_i),
        .div_ready_o (div_ready_o),
        .wb_valid_o  (wb_valid_o),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .wb_ready_i  (wb_ready_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_count"},    64'(count_o),     64'(0));
        check_eq({tag, "_valid"},    64'(wb_valid_o),  64'(0));
        check_eq({tag, "_rd"},       64'(wb_rd_o),     64'(0));
        check_eq({tag, "_data"},     64'(wb_data_o),   64'(0));
        check_eq({tag, "_mul_rdy"},  64'(mul_ready_o), 64'(1));
        check_eq({tag, "_div_rdy"},  64'(div_ready_o), 64'(1));
    endtask

    // Reference model: compare, then apply the handshakes the next edge will see.
    always @(negedge clk) begin
        int   n;
        logic exp_mr, exp_dr;
        ent_t e;
        if (reset) begin
            check_reset_outputs("rst");
            sb.delete();
        end else begin
            n      = sb.size();
            exp_mr = (n < DEPTH);
            exp_dr = (n < DEPTH - 1) || ((n < DEPTH) && !mul_valid_i);
            check_eq("count",     64'(count_o),     64'(n));
            check_eq("wb_valid",  64'(wb_valid_o),  64'(n != 0));
            check_eq("mul_ready", 64'(mul_ready_o), 64'(exp_mr));
            check_eq("div_ready", 64'(div_ready_o), 64'(exp_dr));
            if (n != 0) begin
                e = sb[0];
                check_eq("wb_rd",   64'(wb_rd_o),   64'(e.rd));
                check_eq("wb_data", 64'(wb_data_o), 64'(e.data));
            end else begin
                check_eq("wb_rd_empty",   64'(wb_rd_o),   64'(0));
                check_eq("wb_data_empty", 64'(wb_data_o), 64'(0));
            end
            if (flush_i) begin
                sb.delete();
            end else begin
                if (n != 0 && wb_ready_i) void'(sb.pop_front());
                if (mul_valid_i && exp_mr && mul_rd_i != 0) sb.push_back({mul_rd_i, mul_data_i});
                if (div_valid_i && exp_dr && div_rd_i != 0) sb.push_back({div_rd_i, div_data_i});
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mul(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mul_valid_i = v;
        mul_rd_i    = rd;
        mul_data_i  = d;
    endtask

    task automatic set_div(input logic v, input logic [4:0] rd, input logic [31:0] d);
        div_valid_i = v;
        div_rd_i    = rd;
        div_data_i  = d;
    endtask

    initial begin
        cyc(2);
        reset = 1'b0;

        // Single push into empty queue, then drain.
        set_mul(1'b1, 5'd3, 32'h6);
        cyc();
        set_mul(1'b0, '0, '0);
        check_eq("single_valid", 64'(wb_valid_o), 64'(1));
        check_eq("single_rd",    64'(wb_rd_o),    64'(3));
        cyc();
        wb_ready_i = 1'b1;
        cyc(2);

        // Simultaneous pushes: mul ordered before div.
        wb_ready_i = 1'b0;
        set_mul(1'b1, 5'd1, 32'hAAAA_AAAA);
        set_div(1'b1, 5'd2, 32'h5555_5555);
        cyc();
        set_mul(1'b0, '0, '0);
        set_div(1'b0, '0, '0);
        check_eq("simul_count", 64'(count_o), 64'(2));
        cyc();
        wb_ready_i = 1'b1;
        cyc(3);

        // One free slot: mul takes it, div waits across full and a pop.
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_mul(1'b1, 5'(4 + i), 32'h100 + 32'(i));
            cyc();
        end
        set_mul(1'b1, 5'd7, 32'h107);
        set_div(1'b1, 5'd8, 32'h200);
        cyc();
        set_mul(1'b0, '0, '0);
        cyc();
        check_eq("full_count",   64'(count_o),     64'(4));
        check_eq("full_div_rdy", 64'(div_ready_o), 64'(0));
        wb_ready_i = 1'b1;
        cyc();
        wb_ready_i = 1'b0;
        cyc();
        set_div(1'b0, '0, '0);
        wb_ready_i = 1'b1;
        cyc(6);

        // Wrap-around streaming at one pop per cycle.
        for (int i = 0; i < 10; i++) begin
            set_mul(1'b1, 5'(i + 1), 32'(i));
            cyc();
        end
        set_mul(1'b0, '0, '0);
        cyc(2);

        // rd=0 result accepted but dropped.
        set_mul(1'b1, 5'd0, 32'h1234);
        cyc();
        set_mul(1'b0, '0, '0);
        check_eq("drop_count", 64'(count_o),    64'(0));
        check_eq("drop_valid", 64'(wb_valid_o), 64'(0));
        cyc();

        // Fill, then flush with a pop and a div request pending.
        wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_mul(1'b1, 5'(10 + i), 32'hF0 + 32'(i));
            cyc();
        end
        set_mul(1'b0, '0, '0);
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        set_div(1'b1, 5'd20, 32'hDEAD);
        cyc();
        flush_i = 1'b0;
        set_div(1'b0, '0, '0);
        wb_ready_i = 1'b0;
        check_eq("flush_count", 64'(count_o),    64'(0));
        check_eq("flush_valid", 64'(wb_valid_o), 64'(0));
        cyc();

        // Refill to 2, then asynchronous reset between edges.
        set_mul(1'b1, 5'd21, 32'hABC);
        set_div(1'b1, 5'd22, 32'hDEF);
        cyc();
        set_mul(1'b0, '0, '0);
        set_div(1'b0, '0, '0);
        check_eq("refill_count", 64'(count_o), 64'(2));
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async");
        cyc();
        reset = 1'b0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
